iserdes_sensor_ctrl: RTL and testbench
======================================

# iserdes_sensor_ctrl

Startup sequencer and run-time supervisor for one `iserdes_ddr` 8x oversampling channel in the theremin sensor path. It waits for the sampling PLL to hold lock, then pulses the deserializer reset and enables its clock. It discards the first words, which are invalid, and then forwards the 8-bit sample words with a valid flag. While running it watches the oscillator input for activity and restarts the sequence on lock loss or on request.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 64: consecutive `PLL_LOCKED=1` cycles required before the sequence starts.
- `RESET_CYCLES`, default 8: width of the `SERDES_RESET` pulse, counted after the lock is stable.
- `DISCARD_WORDS`, default 4: number of words dropped after `SERDES_CE` rises.
- `TIMEOUT_CYCLES`, default 1500: number of cycles without an edge before `SIGNAL_LOST` is flagged (10 µs at 150 MHz).

Ports (clock and reset first):
- `CLK`  in  1  parallel-data clock, 150 MHz; the same clock as the deserializer's divided clock.
- `RESET`  in  1  synchronous, active-high reset.
- `PLL_LOCKED`  in  1  lock indicator from the sampling PLL; treated as synchronous to `CLK`.
- `RESTART`  in  1  one-cycle request to rerun the startup sequence.
- `SERDES_DATA`  in  8  word from the deserializer; bit 7 is the newest sample, bit 0 the oldest.
- `SERDES_RESET`  out  1  drives the deserializer reset.
- `SERDES_CE`  out  1  drives the deserializer clock enable.
- `DATA_OUT`  out  8  registered copy of `SERDES_DATA`.
- `DATA_VALID`  out  1  `DATA_OUT` is a valid sample word.
- `READY`  out  1  controller is in the RUN state.
- `SIGNAL_LOST`  out  1  no input edge has been seen for `TIMEOUT_CYCLES` cycles.

## Operation
State machine:
- **IDLE:** `SERDES_RESET=1`, `SERDES_CE=0`.
  - The lock counter increments on each cycle with `PLL_LOCKED=1` and clears on `PLL_LOCKED=0`.
  - When the count reaches `LOCK_STABLE_CYCLES`, go to SRST.
- **SRST:** `SERDES_RESET=1`, `SERDES_CE=0`. After `RESET_CYCLES` cycles, go to SETTLE.
- **SETTLE:** `SERDES_RESET=0`, `SERDES_CE=1`. After `DISCARD_WORDS` cycles, go to RUN.
- **RUN:** `SERDES_RESET=0`, `SERDES_CE=1`, `READY=1`, `DATA_VALID=1`.

Restart rules:
- `PLL_LOCKED=0` in any state except IDLE, or `RESTART=1` in any state, sends the FSM to IDLE on the next cycle.
- The lock counter then restarts from 0.
- `DATA_VALID` and `READY` drop on the same edge; `SIGNAL_LOST` clears.
- If `RESTART` and lock loss occur together, the result is the same single restart.

Activity watchdog (active in RUN only; held cleared in every other state):
- `prev_msb` is the registered value of `SERDES_DATA[7]`.
- A word contains an edge when `SERDES_DATA != {8{prev_msb}}`. This covers transitions inside the word and across the word boundary.
- The idle counter clears on any word with an edge and otherwise increments, saturating at `TIMEOUT_CYCLES`.
- `SIGNAL_LOST` sets when the counter reaches `TIMEOUT_CYCLES`. It clears on the cycle after the next word with an edge.
- Data forwarding continues while `SIGNAL_LOST=1`; no restart is triggered by it.

Width rules:
- Each counter is `$clog2(param+1)` bits wide.
- Counters never wrap; they saturate or reset.

## Timing
- All outputs are registered.
- Reset values: `SERDES_RESET=1`, `SERDES_CE=0`, `DATA_OUT=0`, `DATA_VALID=0`, `READY=0`, `SIGNAL_LOST=0`; FSM in IDLE.
- `RESET` overrides everything, including mid-sequence and in RUN.
- With `PLL_LOCKED` held at 1 from the first cycle after reset release, label that first cycle N:
  - `SERDES_RESET` falls and `SERDES_CE` rises at edge N+`LOCK_STABLE_CYCLES`+`RESET_CYCLES`.
  - `READY` and `DATA_VALID` rise `DISCARD_WORDS` cycles after that.
- `DATA_OUT` has 1 cycle of latency from `SERDES_DATA`; it updates every cycle regardless of state.
- A lock drop during SRST or SETTLE holds or returns `SERDES_RESET` to 1 on the next edge.
- `RESTART` is sampled every cycle. A request held longer than one cycle keeps the FSM in IDLE with the lock counter cleared.

## Structure
- Package `iserdes_ctrl_pkg` holds:
  - the state enum `iserdes_ctrl_state_t` (IDLE, SRST, SETTLE, RUN);
  - the `SERDES_WORD_W=8` constant.
- One sub-module, `iserdes_activity_watchdog`, contains the edge detector, the saturating idle counter and the `SIGNAL_LOST` flag. It has inputs `CLK`, `RESET`, `EN`, `WORD[7:0]` and is parameterised by `TIMEOUT_CYCLES`.
- The top level holds the FSM, the three sequencing counters and the data register.

## Test plan
The bench overrides the parameters to `LOCK_STABLE_CYCLES=4`, `RESET_CYCLES=2`, `DISCARD_WORDS=3`, `TIMEOUT_CYCLES=10`.
1. Clean startup: release reset with lock held at 1 → `SERDES_RESET` falls and `SERDES_CE` rises exactly 6 cycles after the first unreset cycle; `READY` and `DATA_VALID` rise 3 cycles later.
2. Lock glitch in IDLE: `PLL_LOCKED` pattern 1,1,1,0,1,1,1,1 → the lock count restarts after the 0 and `SERDES_RESET` stays 1 until 4 consecutive locked cycles have been seen.
3. Data path in RUN: drive `8'h0F`, `8'hF0`, `8'hAA` → `DATA_OUT` shows the same values one cycle later with `DATA_VALID=1`.
4. Watchdog timing:
   - Constant `8'h00` (with `prev_msb=0`) → `SIGNAL_LOST=1` after 10 cycles.
   - Next word `8'h01` → `SIGNAL_LOST` clears the following cycle.
   - `8'hFF` following `8'h00` counts as an edge.
5. Lock loss in RUN: `PLL_LOCKED=0` for 1 cycle → next cycle shows `READY=0`, `DATA_VALID=0`, `SERDES_RESET=1`, `SERDES_CE=0`; the full 4+2+3 sequence then repeats.
6. Resets mid-sequence:
   - `RESTART` pulse during SETTLE → back to IDLE, with `SERDES_RESET` high the next cycle.
   - `RESET` asserted in RUN → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/iserdes_ctrl_pkg.sv
// Shared types and constants for the iserdes sensor-path controller.
package iserdes_ctrl_pkg;

    localparam int unsigned SERDES_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SRST,
        SETTLE,
        RUN
    } iserdes_ctrl_state_t;

endpackage

// File: rtl/iserdes_activity_watchdog.sv
// Oscillator activity watchdog: flags SIGNAL_LOST after TIMEOUT_CYCLES words without an edge.
module iserdes_activity_watchdog
    import iserdes_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1500
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic [SERDES_WORD_W-1:0] WORD,
    output logic                     SIGNAL_LOST
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             prev_msb_q;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             lost_q;
    logic             word_edge;

    // Comparing against the previous newest sample catches edges across the word boundary too.
    always_comb begin
        word_edge  = (WORD != {SERDES_WORD_W{prev_msb_q}});
        idle_cnt_d = idle_cnt_q;
        if (!EN || word_edge) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_msb_q <= 1'b0;
            idle_cnt_q <= '0;
            lost_q     <= 1'b0;
        end else begin
            prev_msb_q <= WORD[SERDES_WORD_W-1];
            idle_cnt_q <= idle_cnt_d;
            lost_q     <= EN && (idle_cnt_d == CNT_MAX);
        end
    end

    assign SIGNAL_LOST = lost_q;

endmodule

// File: rtl/iserdes_sensor_ctrl.sv
// Startup sequencer and run-time supervisor for one 8x oversampling iserdes channel.
module iserdes_sensor_ctrl
    import iserdes_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 64,
    parameter int unsigned RESET_CYCLES       = 8,
    parameter int unsigned DISCARD_WORDS      = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 1500
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     PLL_LOCKED,
    input  logic                     RESTART,
    input  logic [SERDES_WORD_W-1:0] SERDES_DATA,
    output logic                     SERDES_RESET,
    output logic                     SERDES_CE,
    output logic [SERDES_WORD_W-1:0] DATA_OUT,
    output logic                     DATA_VALID,
    output logic                     READY,
    output logic                     SIGNAL_LOST
);

    localparam int unsigned LOCK_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned DISC_W = $clog2(DISCARD_WORDS + 1);

    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_STABLE_CYCLES);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISCARD_WORDS - 1);

    iserdes_ctrl_state_t state_q, state_d;

    logic [LOCK_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [DISC_W-1:0]        disc_cnt_q, disc_cnt_d;
    logic                     serdes_reset_q, serdes_ce_q, ready_q;
    logic [SERDES_WORD_W-1:0] data_q;
    logic                     restart_req;
    logic                     run_next;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = '0;
        rst_cnt_d   = '0;
        disc_cnt_d  = '0;
        restart_req = RESTART || (!PLL_LOCKED && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (!PLL_LOCKED) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_MAX) begin
                    state_d = SRST;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            SRST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (disc_cnt_q == DISC_LAST) begin
                    state_d = RUN;
                end else begin
                    disc_cnt_d = disc_cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A restart wins over any sequencing progress and restarts every counter from zero.
        if (restart_req) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
            rst_cnt_d  = '0;
            disc_cnt_d = '0;
        end

        run_next = (state_d == RUN);
    end

    // Outputs are decoded from the next state so they land on the same edge as the transition.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            lock_cnt_q     <= '0;
            rst_cnt_q      <= '0;
            disc_cnt_q     <= '0;
            serdes_reset_q <= 1'b1;
            serdes_ce_q    <= 1'b0;
            ready_q        <= 1'b0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            rst_cnt_q      <= rst_cnt_d;
            disc_cnt_q     <= disc_cnt_d;
            serdes_reset_q <= (state_d == IDLE) || (state_d == SRST);
            serdes_ce_q    <= (state_d == SETTLE) || (state_d == RUN);
            ready_q        <= run_next;
            data_q         <= SERDES_DATA;
        end
    end

    iserdes_activity_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK        (CLK),
        .RESET      (RESET),
        .EN         (run_next),
        .WORD       (SERDES_DATA),
        .SIGNAL_LOST(SIGNAL_LOST)
    );

    assign SERDES_RESET = serdes_reset_q;
    assign SERDES_CE    = serdes_ce_q;
    assign DATA_OUT     = data_q;
    assign DATA_VALID   = ready_q;
    assign READY        = ready_q;

endmodule

// File: tb/tb_iserdes_sensor_ctrl.sv
// Self-checking bench for iserdes_sensor_ctrl against a lock-run-length reference model.
module tb_iserdes_sensor_ctrl;

    localparam int L = 4;
    localparam int R = 2;
    localparam int D = 3;
    localparam int T = 10;
    localparam logic [0:7] PAT = 8'b1110_1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] data = 8'h00;
    logic       sreset, ce, valid, ready, lost;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    // Reference model: the whole sequence follows from how many consecutive clean locked edges
    // have been seen since the last reset, lock drop or restart request.
    int         run_len = 0;
    int         m_idle = 0;
    logic       m_prev = 1'b0;
    logic       m_lost = 1'b0;
    logic [7:0] m_data = 8'h00;

    iserdes_sensor_ctrl #(
        .LOCK_STABLE_CYCLES(L),
        .RESET_CYCLES      (R),
        .DISCARD_WORDS     (D),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .PLL_LOCKED  (lock),
        .RESTART     (restart),
        .SERDES_DATA (data),
        .SERDES_RESET(sreset),
        .SERDES_CE   (ce),
        .DATA_OUT    (dout),
        .DATA_VALID  (valid),
        .READY       (ready),
        .SIGNAL_LOST (lost)
    );

    wire [4:0] ctl = {sreset, ce, ready, valid, lost};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic rdy;
        if (rst) begin
            run_len = 0;
            m_idle  = 0;
            m_prev  = 1'b0;
            m_lost  = 1'b0;
            m_data  = 8'h00;
        end else begin
            if (!lock || restart) run_len = 0;
            else if (run_len < 1000) run_len = run_len + 1;
            rdy = (run_len > L + R + D);
            if (!rdy || (data != {8{m_prev}})) m_idle = 0;
            else if (m_idle < T) m_idle = m_idle + 1;
            m_lost = rdy && (m_idle >= T);
            m_prev = data[7];
            m_data = data;
        end
    end

    function automatic logic [4:0] exp_ctl();
        logic rdy;
        rdy = (run_len > L + R + D);
        return {run_len <= L + R, run_len > L + R, rdy, rdy, m_lost};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lock = 1'b1;
        data = 8'h5A;
        repeat (3) tick();
        checks += 6;
        if (sreset !== 1'b1) begin errors++; $display("FAIL reset_sreset got %b exp 1", sreset); end
        if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", ce); end
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b exp 0", lost); end
    endtask

    task automatic test_startup();
        int ce_rise = -1;
        int rdy_rise = -1;
        rst = 1'b0;
        lock = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks += 2;
            if (ctl !== exp_ctl()) begin
                errors++;
                $display("FAIL startup_ctl cyc %0d got %b exp %b", i, ctl, exp_ctl());
            end
            if (dout !== m_data) begin
                errors++;
                $display("FAIL startup_dout cyc %0d got %h exp %h", i, dout, m_data);
            end
            if (ce === 1'b1 && ce_rise < 0) ce_rise = i;
            if (ready === 1'b1 && rdy_rise < 0) rdy_rise = i;
            data = 8'($urandom);
        end
        checks += 2;
        if (ce_rise != 6) begin errors++; $display("FAIL startup_ce_rise got %0d exp 6", ce_rise); end
        if (rdy_rise != 9) begin errors++; $display("FAIL startup_ready_rise got %0d exp 9", rdy_rise); end
    endtask

    task automatic test_lock_glitch();
        int ce_rise = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            lock = (i < 8) ? PAT[i] : 1'b1;
            tick();
            checks++;
            if (ctl !== exp_ctl()) begin
                errors++;
                $display("FAIL glitch_ctl cyc %0d got %b exp %b", i, ctl, exp_ctl());
            end
            if (ce === 1'b1 && ce_rise < 0) ce_rise = i;
        end
        checks++;
        if (ce_rise != 10) begin errors++; $display("FAIL glitch_ce_rise got %0d exp 10", ce_rise); end
    endtask

    task automatic test_data_path();
        logic [7:0] vals [3] = '{8'h0F, 8'hF0, 8'hAA};
        for (int k = 0; k < 3; k++) begin
            data = vals[k];
            tick();
            checks += 2;
            if (dout !== vals[k]) begin
                errors++;
                $display("FAIL data_out word %0d got %h exp %h", k, dout, vals[k]);
            end
            if (valid !== 1'b1) begin
                errors++;
                $display("FAIL data_valid word %0d got %b exp 1", k, valid);
            end
        end
    endtask

    task automatic test_watchdog();
        int lost_at = -1;
        data = 8'h00;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (ctl !== exp_ctl()) begin
                errors++;
                $display("FAIL wd_ctl cyc %0d got %b exp %b", i, ctl, exp_ctl());
            end
            if (lost === 1'b1 && lost_at < 0) lost_at = i;
        end
        checks++;
        if (lost_at != 10) begin errors++; $display("FAIL wd_lost_at got %0d exp 10", lost_at); end
        data = 8'h01;
        tick();
        checks++;
        if (lost !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp 0", lost); end
        data = 8'h00;
        repeat (5) tick();
        data = 8'hFF;
        repeat (10) tick();
        checks++;
        if (lost !== 1'b0) begin errors++; $display("FAIL wd_ff_edge got %b exp 0", lost); end
        tick();
        checks++;
        if (lost !== 1'b1) begin errors++; $display("FAIL wd_ff_timeout got %b exp 1", lost); end
    endtask

    task automatic test_lock_loss_run();
        int ce_rise = -1;
        int rdy_rise = -1;
        lock = 1'b0;
        tick();
        checks++;
        if (ctl !== 5'b10000) begin errors++; $display("FAIL lossrun_drop got %b exp 10000", ctl); end
        lock = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            data = 8'($urandom);
            tick();
            checks++;
            if (ctl !== exp_ctl()) begin
                errors++;
                $display("FAIL lossrun_ctl cyc %0d got %b exp %b", i, ctl, exp_ctl());
            end
            if (ce === 1'b1 && ce_rise < 0) ce_rise = i;
            if (ready === 1'b1 && rdy_rise < 0) rdy_rise = i;
        end
        checks += 2;
        if (ce_rise != 7) begin errors++; $display("FAIL lossrun_ce_rise got %0d exp 7", ce_rise); end
        if (rdy_rise != 10) begin errors++; $display("FAIL lossrun_rdy_rise got %0d exp 10", rdy_rise); end
    endtask

    task automatic test_restart_settle();
        int n = 0;
        int ce_rise = -1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (ctl !== 5'b10000) begin errors++; $display("FAIL restart_run got %b exp 10000", ctl); end
        while (ce !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ce !== 1'b1) begin errors++; $display("FAIL restart_reach_settle got %b exp 1", ce); end
        tick();
        restart = 1'b1;
        tick();
        checks++;
        if ({sreset, ce, ready} !== 3'b100) begin
            errors++;
            $display("FAIL restart_settle got %b exp 100", {sreset, ce, ready});
        end
        repeat (5) tick();
        checks++;
        if (sreset !== 1'b1) begin errors++; $display("FAIL restart_held got %b exp 1", sreset); end
        restart = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (ce === 1'b1 && ce_rise < 0) ce_rise = i;
        end
        checks++;
        if (ce_rise != 7) begin errors++; $display("FAIL restart_ce_rise got %0d exp 7", ce_rise); end
    endtask

    task automatic test_reset_in_run();
        data = 8'h00;
        repeat (15) tick();
        checks++;
        if ({ready, lost} !== 2'b11) begin
            errors++;
            $display("FAIL rstrun_pre got %b exp 11", {ready, lost});
        end
        data = 8'h3C;
        rst = 1'b1;
        tick();
        checks += 2;
        if (ctl !== 5'b10000) begin errors++; $display("FAIL rstrun_ctl got %b exp 10000", ctl); end
        if (dout !== 8'h00) begin errors++; $display("FAIL rstrun_dout got %h exp 00", dout); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int mode = 0;
        for (int c = 0; c < 800; c++) begin
            if (c % 20 == 0) mode = int'($urandom_range(0, 2));
            rst = ($urandom_range(0, 299) == 0);
            lock = ($urandom_range(0, 39) != 0);
            restart = ($urandom_range(0, 59) == 0);
            case (mode)
                0: data = 8'($urandom);
                1: data = 8'h00;
                default: data = (c % 20 == 0) ? 8'h01 : 8'hFF;
            endcase
            tick();
            checks += 2;
            if (ctl !== exp_ctl()) begin
                errors++;
                $display("FAIL random_ctl cyc %0d got %b exp %b", c, ctl, exp_ctl());
            end
            if (dout !== m_data) begin
                errors++;
                $display("FAIL random_dout cyc %0d got %h exp %h", c, dout, m_data);
            end
        end
        rst = 1'b0;
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_lock_glitch();
        test_data_path();
        test_watchdog();
        test_lock_loss_run();
        test_restart_settle();
        test_reset_in_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
